// File: rtl/module_bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// One iteration per clock; the result is presented for one cycle with a
// write strobe for the downstream 7-segment display driver. Inputs above
// the largest representable BCD value saturate to all nines and set ovf.
module module_bin2bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  start,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  we,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    localparam int unsigned          MAX_BCD   = pow10(DIGITS) - 1;
    localparam logic [BIN_W:0]       THRESH    = (BIN_W + 1)'(MAX_BCD);
    localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(BIN_W - 1);
    localparam logic [BCD_W-1:0]     ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    state_t               state;
    logic [BIN_W-1:0]     shreg;
    logic [BCD_W-1:0]     scratch;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_pend;

    logic [BCD_W-1:0]     scratch_nxt;
    logic [BIN_W-1:0]     shreg_nxt;

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift left.
    // The carry chains nibble to nibble; the carry out of the top nibble is
    // dropped since it only occurs on overflow, which is saturated anyway.
    always_comb begin
        logic [3:0] dig;
        logic       carry;
        scratch_nxt = '0;
        dig         = '0;
        carry       = shreg[BIN_W-1];
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = scratch[4*i +: 4];
            if (dig >= 4'd5) begin
                dig = dig + 4'd3;
            end
            scratch_nxt[4*i +: 4] = {dig[2:0], carry};
            carry = dig[3];
        end
        shreg_nxt = {shreg[BIN_W-2:0], 1'b0};
    end

    // Control FSM with registered outputs; bcd_out and ovf only change with we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            bcd_out  <= '0;
            we       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        shreg    <= bin_in;
                        scratch  <= '0;
                        cnt      <= '0;
                        ovf_pend <= {1'b0, bin_in} > THRESH;
                        busy     <= 1'b1;
                        state    <= StShift;
                    end
                end
                StShift: begin
                    shreg   <= shreg_nxt;
                    scratch <= scratch_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        bcd_out <= ovf_pend ? ALL_NINES : scratch_nxt;
                        ovf     <= ovf_pend;
                        we      <= 1'b1;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    we    <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_bin2bcd_seq.sv
// Scoreboard bench for module_bin2bcd_seq: the stimulus pushes the expected
// {ovf, bcd} for each accepted start, and a monitor pops on every we pulse.
module tb_module_bin2bcd_seq;

    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned BCD_W  = 4 * DIGITS;

    logic               clk;
    logic               rst_n;
    logic [BIN_W-1:0]   bin_in;
    logic               start;
    logic               busy;
    logic [BCD_W-1:0]   bcd_out;
    logic               we;
    logic               ovf;

    int tests_run = 0;
    int failures  = 0;
    int we_cnt    = 0;
    int push_cnt  = 0;

    logic [BCD_W:0] sb[$];

    module_bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .start   (start),
        .busy    (busy),
        .bcd_out (bcd_out),
        .we      (we),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits via / and %, saturating above 9999.
    function automatic logic [BCD_W:0] model(input int v);
        if (v > 9999) return {1'b1, 16'h9999};
        return {1'b0, 4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every we pulse must match the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (we === 1'b1) begin
            logic [BCD_W:0] exp;
            we_cnt++;
            tests_run++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_we: got bcd=%h ovf=%b expected no write", bcd_out, ovf);
            end else begin
                exp = sb.pop_front();
                if ({ovf, bcd_out} !== exp) begin
                    failures++;
                    $display("FAIL result: got ovf=%b bcd=%h expected ovf=%b bcd=%h",
                             ovf, bcd_out, exp[BCD_W], exp[BCD_W-1:0]);
                end
            end
        end
    end

    // Returns at a falling edge with busy low, or flags a timeout.
    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        tests_run++;
        failures++;
        $display("FAIL idle_timeout: got busy=1 expected busy=0 within 100 cycles");
    endtask

    // Issue one start; returns #1 after the accepting edge E0 with start low.
    task automatic issue(input int v, input bit push);
        wait_idle();
        start  = 1'b1;
        bin_in = BIN_W'(v);
        if (push) begin
            sb.push_back(model(v));
            push_cnt++;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
    endtask

    // Conversion with cycle-exact checks of we and busy after E0.
    task automatic issue_timed(input int v);
        issue(v, 1'b1);
        for (int k = 1; k <= int'(BIN_W) + 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("we_at_E%0d", k), 32'(we), 32'(k == int'(BIN_W)));
            check($sformatf("busy_at_E%0d", k), 32'(busy), 32'(k <= int'(BIN_W)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #23;
        check("reset_bcd", 32'(bcd_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_we", 32'(we), 32'h0);
        check("reset_ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: basic latency and hold
        issue_timed(255);
        repeat (5) @(negedge clk);
        check("hold_bcd_255", 32'(bcd_out), 32'h0255);
        check("hold_ovf_255", 32'(ovf), 32'h0);

        // 2: top of range and zero
        issue(9999, 1'b1);
        issue_timed(0);

        // 3: overflow saturation, then recovery
        issue_timed(12345);
        check("hold_ovf_sat", 32'(ovf), 32'h1);
        issue(42, 1'b1);
        wait_idle();
        check("after_sat_bcd", 32'(bcd_out), 32'h0042);
        check("after_sat_ovf", 32'(ovf), 32'h0);

        // 4: start held high through busy; next accept at E_BIN_W+2
        wait_idle();
        start  = 1'b1;
        bin_in = BIN_W'(100);
        sb.push_back(model(100));
        push_cnt++;
        @(posedge clk);
        #1;
        bin_in = BIN_W'(777);
        sb.push_back(model(777));
        push_cnt++;
        for (int k = 1; k <= int'(BIN_W) + 2; k++) begin
            @(posedge clk);
            #1;
            if (k == int'(BIN_W) + 1) check("held_start_idle", 32'(busy), 32'h0);
            if (k == int'(BIN_W) + 2) check("held_start_accept", 32'(busy), 32'h1);
        end
        start = 1'b0;
        wait_idle();
        check("held_start_bcd", 32'(bcd_out), 32'h0777);

        // 5: reset mid-conversion aborts without a write
        issue(4321, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_bcd", 32'(bcd_out), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_we", 32'(we), 32'h0);
        check("abort_ovf", 32'(ovf), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4321, 1'b1);
        wait_idle();
        check("restart_bcd", 32'(bcd_out), 32'h4321);

        // 6: strided sweep plus boundaries
        for (int v = 0; v <= 9999; v += 97) issue(v, 1'b1);
        issue(9998, 1'b1);
        issue(10000, 1'b1);
        issue(16383, 1'b1);
        issue(1, 1'b1);

        wait_idle();
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        check("we_per_start", 32'(we_cnt), 32'(push_cnt));

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
